// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Issue stage in front of the 64-bit ALU. Each cycle it can accept one decoded
// instruction. It generates the 4-bit ALU control code and selects operand B
// from either rs2 or the immediate. The result is held in a main register
// backed by a skid entry, and the main register drives the ALU inputs.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   alu_op, funct3,
//   funct7_5, alu_src     decode fields
//   rs1_data, rs2_data,
//   imm, rd               operands and destination index
//   flush                 drop every buffered entry at the next edge
//   out_valid / out_ready downstream handshake
//   alu_a, alu_b,
//   alu_control, out_rd,
//   illegal               main-entry payload presented to the ALU
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned RD_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [RD_W-1:0]  rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    output logic [RD_W-1:0]  out_rd,
    output logic             illegal
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
        logic [RD_W-1:0]  rd;
        logic             illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t new_entry;
    logic   accept;
    logic   consume;

    // Decode the incoming fields into the entry that would be captured this cycle.
    always_comb begin
        new_entry         = '0;
        new_entry.a       = rs1_data;
        new_entry.b       = alu_src ? imm : rs2_data;
        new_entry.rd      = rd;
        new_entry.ctrl    = CTRL_ADD;
        new_entry.illegal = 1'b0;
        case (alu_op)
            2'b00: new_entry.ctrl = CTRL_ADD;
            2'b01: new_entry.ctrl = CTRL_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  new_entry.ctrl = funct7_5 ? CTRL_SUB : CTRL_ADD;
                    3'b111:  new_entry.ctrl = CTRL_AND;
                    3'b110:  new_entry.ctrl = CTRL_OR;
                    default: new_entry.illegal = 1'b1;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000:  new_entry.ctrl = CTRL_ADD;
                    3'b111:  new_entry.ctrl = CTRL_AND;
                    3'b110:  new_entry.ctrl = CTRL_OR;
                    default: new_entry.illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Occupancy FSM with main/skid storage; flush overrides any transfer this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= new_entry;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= new_entry;
                    end else if (accept) begin
                        skid_q   <= new_entry;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (consume) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (consume) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign alu_a       = main_q.a;
    assign alu_b       = main_q.b;
    assign alu_control = main_q.ctrl;
    assign out_rd      = main_q.rd;
    assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed and randomized stimulus for alu_issue_stage. The expected outputs
// come from an in-order queue model of the stage (at most two entries in
// flight) and from a rule-table decode of the instruction fields.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        alu_src;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_control;
    logic [4:0]  out_rd;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t shown;
    int   consumed;

    alu_issue_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_src     (alu_src),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .rd          (rd),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .out_rd      (out_rd),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected entry for the current inputs, written as a rule table.
    function automatic exp_t model_entry();
        exp_t e;
        e.a    = rs1_data;
        e.b    = (alu_src == 1'b1) ? imm : rs2_data;
        e.rd   = rd;
        e.ill  = 1'b0;
        e.ctrl = 4'd2;
        if (alu_op == 2'd0)       e.ctrl = 4'd2;
        else if (alu_op == 2'd1)  e.ctrl = 4'd6;
        else if (funct3 == 3'd7)  e.ctrl = 4'd0;
        else if (funct3 == 3'd6)  e.ctrl = 4'd1;
        else if (funct3 == 3'd0)  e.ctrl = (alu_op == 2'd2 && funct7_5) ? 4'd6 : 4'd2;
        else                      e.ill  = 1'b1;
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
        chk({tag, ".alu_a"},     alu_a,          shown.a);
        chk({tag, ".alu_b"},     alu_b,          shown.b);
        chk({tag, ".alu_ctrl"},  64'(alu_control), 64'(shown.ctrl));
        chk({tag, ".out_rd"},    64'(out_rd),    64'(shown.rd));
        chk({tag, ".illegal"},   64'(illegal),   64'(shown.ill));
    endtask

    // Advance one clock edge and update the queue model the same way.
    task automatic step();
        bit   acc;
        bit   con;
        exp_t e;
        acc = in_valid && (q.size() < 2);
        con = (q.size() > 0) && out_ready;
        e   = model_entry();
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (con) begin
                void'(q.pop_front());
                consumed++;
            end
            if (acc) q.push_back(e);
        end
        if (q.size() > 0) shown = q[0];
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [2:0] f3,
                          input logic f7, input logic src, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [63:0] im, input logic [4:0] d);
        in_valid = v;
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f7;
        alu_src  = src;
        rs1_data = r1;
        rs2_data = r2;
        imm      = im;
        rd       = d;
    endtask

    task automatic rand_in(input logic v);
        set_in(v, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
    endtask

    task automatic clear_model();
        q.delete();
        shown = '{a: 64'd0, b: 64'd0, ctrl: 4'd0, rd: 5'd0, ill: 1'b0};
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        consumed  = 0;
        set_in(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0);
        clear_model();
        #1;
        check_all("reset_init");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Decode sweep with the consumer always ready.
        out_ready = 1'b1;
        set_in(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 64'd1245, 64'd976, 64'd0, 5'd3);
        step();
        check_all("dec_sub");
        chk("dec_sub.ctrl_const", 64'(alu_control), 64'd6);
        chk("dec_sub.a_const", alu_a, 64'd1245);
        chk("dec_sub.b_const", alu_b, 64'd976);
        set_in(1'b1, 2'b11, 3'b111, 1'b1, 1'b1, 64'd77, 64'd99, 64'd5, 5'd4);
        step();
        check_all("dec_andi");
        chk("dec_andi.ctrl_const", 64'(alu_control), 64'd0);
        chk("dec_andi.b_const", alu_b, 64'd5);
        set_in(1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd5);
        step();
        check_all("dec_illegal");
        chk("dec_illegal.ctrl_const", 64'(alu_control), 64'd2);
        chk("dec_illegal.ill_const", 64'(illegal), 64'd1);
        set_in(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0);
        step();
        check_all("drain");

        // Backpressure: A held, B fills skid, C waits until space frees.
        out_ready = 1'b0;
        set_in(1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 64'hA, 64'hA0, 64'd0, 5'd10);
        step();
        check_all("bp_a");
        set_in(1'b1, 2'b01, 3'd0, 1'b0, 1'b0, 64'hB, 64'hB0, 64'd0, 5'd11);
        step();
        check_all("bp_b");
        chk("bp_b.in_ready_low", 64'(in_ready), 64'd0);
        set_in(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 64'hC, 64'hC0, 64'd0, 5'd12);
        step();
        check_all("bp_c_wait");
        chk("bp_c_wait.rd_a_held", 64'(out_rd), 64'd10);
        out_ready = 1'b1;
        step();
        check_all("bp_rel1");
        chk("bp_rel1.rd_b", 64'(out_rd), 64'd11);
        step();
        check_all("bp_rel2");
        chk("bp_rel2.rd_c", 64'(out_rd), 64'd12);
        in_valid = 1'b0;
        step();
        check_all("bp_rel3");

        // Eight back-to-back ops at full throughput.
        consumed = 0;
        for (int i = 0; i < 8; i++) begin
            rand_in(1'b1);
            step();
            check_all($sformatf("tput%0d", i));
            chk($sformatf("tput%0d.valid", i), 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check_all("tput_drain");
        chk("tput.count", 64'(consumed), 64'd8);

        // Flush while FULL with a simultaneous input.
        out_ready = 1'b0;
        rand_in(1'b1);
        step();
        rand_in(1'b1);
        step();
        check_all("fl_full");
        rand_in(1'b1);
        flush = 1'b1;
        step();
        check_all("fl_edge");
        chk("fl_edge.valid_low", 64'(out_valid), 64'd0);
        chk("fl_edge.ready_high", 64'(in_ready), 64'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_all("fl_after");
        chk("fl_after.no_ghost", 64'(out_valid), 64'd0);

        // Accept and consume together while ONE.
        set_in(1'b1, 2'b11, 3'b110, 1'b0, 1'b1, 64'h11, 64'h22, 64'h33, 5'd20);
        step();
        check_all("ac_one");
        set_in(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 64'h44, 64'h55, 64'h66, 5'd21);
        step();
        check_all("ac_both");
        chk("ac_both.rd_new", 64'(out_rd), 64'd21);
        chk("ac_both.ready", 64'(in_ready), 64'd1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            rand_in(1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
            check_all($sformatf("rnd%0d", i));
        end
        flush = 1'b0;

        // Reset mid-stream: takes effect before the next edge.
        out_ready = 1'b0;
        rand_in(1'b1);
        step();
        rand_in(1'b1);
        step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        clear_model();
        check_all("reset_mid");
        chk("reset_mid.ctrl", 64'(alu_control), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check_all("reset_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
